// File: rtl/gelato_pkg.sv
// Shared types and sizing for the gelato per-warp instruction buffer.
package gelato_pkg;

  localparam int unsigned NUM_WARPS   = 8;
  localparam int unsigned DEPTH       = 2;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned INST_WIDTH  = 32;
  localparam int unsigned SPLIT_WIDTH = 5;

  localparam int unsigned WARP_W = $clog2(NUM_WARPS);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef logic [WARP_W-1:0]      warp_num_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INST_WIDTH-1:0]  inst_t;
  typedef logic [SPLIT_WIDTH-1:0] split_num_t;
  typedef logic [CNT_W-1:0]       cnt_t;

  typedef struct packed {
    addr_t      pc;
    inst_t      inst;
    split_num_t split;
  } ibuf_entry_t;

  // A warp can take another reservation only if buffered plus in-flight leaves a free slot.
  function automatic logic has_space(input cnt_t count, input cnt_t pend);
    return ((CNT_W+1)'(count) + (CNT_W+1)'(pend)) < (CNT_W+1)'(DEPTH);
  endfunction

endpackage

// File: rtl/gelato_warp_fifo.sv
// Single-warp instruction FIFO with synchronous clear; clear wins over a same-cycle push.
module gelato_warp_fifo
  import gelato_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  ibuf_entry_t data_i,
  output ibuf_entry_t head_o,
  output cnt_t        count_o
);

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  cnt_t             count_q;
  ibuf_entry_t      mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && !clear_i && ((count_q != cnt_t'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  // Storage carries no reset; only entries below count_q are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer: slot reservation, in-flight drop on flush,
// round-robin feed of one instruction per cycle into a registered output.
module gelato_inst_buffer
  import gelato_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rsv_valid,
  input  warp_num_t            rsv_warp,
  output logic [NUM_WARPS-1:0] warp_space,
  input  logic                 in_valid,
  input  addr_t                in_pc,
  input  inst_t                in_inst,
  input  warp_num_t            in_warp,
  input  split_num_t           in_split,
  input  logic                 flush_valid,
  input  warp_num_t            flush_warp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output addr_t                out_pc,
  output inst_t                out_inst,
  output warp_num_t            out_warp,
  output split_num_t           out_split,
  output logic                 err
);

  cnt_t                 count_w [NUM_WARPS];
  ibuf_entry_t          head_w  [NUM_WARPS];
  cnt_t                 pend_q  [NUM_WARPS];
  cnt_t                 pend_d  [NUM_WARPS];
  cnt_t                 drop_q  [NUM_WARPS];
  cnt_t                 drop_d  [NUM_WARPS];
  logic [NUM_WARPS-1:0] push;
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] clear;
  logic [NUM_WARPS-1:0] req;
  logic                 err_q, err_d;
  warp_num_t            last_grant_q;
  logic                 out_valid_q;
  ibuf_entry_t          out_q;
  warp_num_t            out_warp_q;
  ibuf_entry_t          in_entry;
  logic                 load;
  logic                 found;
  warp_num_t            winner;

  assign in_entry = '{pc: in_pc, inst: in_inst, split: in_split};

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_fifo
    gelato_warp_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .clear_i (clear[g]),
      .data_i  (in_entry),
      .head_o  (head_w[g]),
      .count_o (count_w[g])
    );
  end

  always_comb begin
    warp_space = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      warp_space[w] = has_space(count_w[w], pend_q[w]);
    end
  end

  // Per-warp bookkeeping in order: arrival, then flush, then reservation.
  always_comb begin
    logic rsv_hit, arr_hit, fl_hit;
    cnt_t pend_a, drop_a;
    err_d   = err_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    push    = '0;
    clear   = '0;
    req     = '0;
    rsv_hit = 1'b0;
    arr_hit = 1'b0;
    fl_hit  = 1'b0;
    pend_a  = '0;
    drop_a  = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      rsv_hit = rdy && rsv_valid   && (rsv_warp   == warp_num_t'(w));
      arr_hit = rdy && in_valid    && (in_warp    == warp_num_t'(w));
      fl_hit  = rdy && flush_valid && (flush_warp == warp_num_t'(w));
      pend_a  = pend_q[w];
      drop_a  = drop_q[w];
      if (arr_hit) begin
        if (pend_q[w] == '0) begin
          err_d = 1'b1;
        end else begin
          pend_a = pend_q[w] - cnt_t'(1);
          if (drop_q[w] != '0) drop_a = drop_q[w] - cnt_t'(1);
          else                 push[w] = 1'b1;
        end
      end
      if (fl_hit) drop_a = pend_a;
      pend_d[w] = pend_a;
      drop_d[w] = drop_a;
      if (rsv_hit) begin
        if (!warp_space[w]) err_d = 1'b1;
        if (pend_a != cnt_t'(DEPTH)) pend_d[w] = pend_a + cnt_t'(1);
      end
      clear[w] = fl_hit;
      req[w]   = rdy && (count_w[w] != '0) && !fl_hit;
    end
  end

  // Round-robin pick starting one past the last grant.
  always_comb begin
    warp_num_t idx;
    load   = !out_valid_q || out_ready;
    found  = 1'b0;
    winner = last_grant_q;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = last_grant_q + warp_num_t'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    pop = '0;
    if (load && found) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_warp_q   <= '0;
      last_grant_q <= warp_num_t'(NUM_WARPS - 1);
      err_q        <= 1'b0;
      pend_q       <= '{default: '0};
      drop_q       <= '{default: '0};
    end else if (rdy) begin
      err_q  <= err_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      if (load) begin
        out_valid_q <= found;
        if (found) begin
          out_q        <= head_w[winner];
          out_warp_q   <= winner;
          last_grant_q <= winner;
        end
      end else if (flush_valid && (flush_warp == out_warp_q)) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_inst  = out_q.inst;
  assign out_split = out_q.split;
  assign out_warp  = out_warp_q;
  assign err       = err_q;

endmodule
